// File: rtl/input_debouncer_if.sv
// Bundle carrying the raw inputs to the debouncer and its conditioned
// level and edge-pulse outputs back to the user logic.
interface input_debouncer_if #(
  parameter int N_IN = 6
);
  logic [N_IN-1:0] din;
  logic [N_IN-1:0] dout;
  logic [N_IN-1:0] rise;
  logic [N_IN-1:0] fall;

  // master drives raw inputs and consumes conditioned outputs
  modport master (output din, input dout, input rise, input fall);
  // slave is the debouncer itself
  modport slave  (input din, output dout, output rise, output fall);
endinterface

// File: rtl/input_debouncer.sv
// Per-bit synchronizer and debounce filter for board keys and switches.
// Each bit is resynchronized through a SYNC_STAGES-deep chain, then must
// differ from the accepted level for DB_CYCLES consecutive clocks before
// the new level is taken; a one-cycle rise/fall pulse marks the change.
module input_debouncer #(
  parameter int              N_IN        = 6,
  parameter int              DB_CYCLES   = 1_000_000,
  parameter int              SYNC_STAGES = 2,
  parameter logic [N_IN-1:0] IDLE_LEVEL  = 6'b000011
) (
  input  logic              clk,
  input  logic              rst,
  input_debouncer_if.slave  bus
);

  // Counter only has to reach DB_CYCLES-1, so $clog2 bits are enough.
  localparam int            CW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [N_IN-1:0] sync_q [SYNC_STAGES];
  logic [N_IN-1:0] sync_last;

  logic [CW-1:0]   cnt_q [N_IN];
  logic [CW-1:0]   cnt_d [N_IN];

  logic [N_IN-1:0] dout_q;
  logic [N_IN-1:0] dout_d;
  logic [N_IN-1:0] rise_q;
  logic [N_IN-1:0] rise_d;
  logic [N_IN-1:0] fall_q;
  logic [N_IN-1:0] fall_d;

  assign sync_last = sync_q[SYNC_STAGES-1];

  // Synchronizer chain; stages reset to the idle level so no spurious count
  // starts when reset is released with idle inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= IDLE_LEVEL;
      end
    end else begin
      sync_q[0] <= bus.din;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // Next-state filter: count consecutive disagreements, accept on the last one.
  always_comb begin
    dout_d = dout_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < N_IN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_last[i] == dout_q[i]) begin
        // agreement (or bounce back) discards any partial count
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        cnt_d[i]  = '0;
        dout_d[i] = sync_last[i];
        rise_d[i] = sync_last[i];
        fall_d[i] = ~sync_last[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Filter state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= IDLE_LEVEL;
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < N_IN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      dout_q <= dout_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      for (int i = 0; i < N_IN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.dout = dout_q;
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;

endmodule
